display_scan_ctrl: RTL
======================

Name: display_scan_ctrl

Overview:
Time-multiplexes one shared 5-input seven-segment decoder across NDIG digits, each digit with its own common-select line.
- Holds a double-buffered copy of all digit codes.
- Steps through the digits at a fixed slot period.
- Inserts a blanking guard interval between digits to suppress ghosting.
- Sits between the system logic that produces the codes and the seven-segment decoder plus digit drivers.

Parameters:
NDIG, 4, number of multiplexed digits (2..8)
W, 5, code width per digit; matches the decoder inputs c1..c5
PRESC, 1000, clk cycles a digit is driven per slot (>=16)
GUARD, 8, blank clk cycles before each slot (0..PRESC-1; 0 = no guard)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable
upd  in  1  one-cycle strobe: capture codes into staging
codes  in  NDIG*W  digit codes; digit i at [i*W +: W]; digit 0 = leftmost
upd_ack  out  1  pulse one cycle after upd is captured
code_out  out  W  code driven to the shared decoder
dig_n  out  NDIG  digit selects, active-low, at most one low
slot_done  out  1  pulse on the last ON cycle of each slot
frame_done  out  1  pulse on the last ON cycle of digit NDIG-1

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, counter=0.
  - staging=0, active=0, pending=0.
  - code_out=0, dig_n=all 1s.
  - upd_ack=0, slot_done=0, frame_done=0.
- All outputs are registered.
- States:
  - IDLE:
    - dig_n all 1s, code_out=0.
    - When en=1: go to GUARD with idx=0, or straight to ON if GUARD=0.
  - GUARD:
    - dig_n all 1s, code_out=active[idx].
    - Counts exactly GUARD cycles, then ON.
  - ON:
    - dig_n[idx]=0, code_out=active[idx].
    - Counts exactly PRESC cycles.
    - On the last ON cycle: slot_done=1.
    - If idx==NDIG-1, also frame_done=1; on the following edge idx wraps to 0, and if pending=1 then active<=staging and pending<=0.
    - Otherwise idx increments.
    - Next state is GUARD (or ON if GUARD=0).
- Slot period: GUARD+PRESC cycles. Frame period: NDIG*(GUARD+PRESC).
- en=0 in any state:
  - Next cycle goes to IDLE; idx and counter cleared.
  - No slot_done or frame_done for the aborted slot.
  - Staging, active and pending are kept.
- en re-asserted: scan restarts at digit 0 from GUARD.
- upd:
  - staging<=codes, pending<=1, upd_ack=1 on the next cycle.
  - Back-to-back upd: last write wins; one ack per strobe.
- Transfer in IDLE: if pending=1, active<=staging on the following cycle.
- upd in the same cycle as the frame-boundary transfer: the boundary copies the old staging; the new data stays pending for the next frame.
- Active is never written mid-frame, so a frame never tears.
- Counters are sized $clog2(PRESC); idx is sized $clog2(NDIG), minimum 1 bit.

Optional Feature:
DISPLAY_SCAN_DIM_EN
- Defined:
  - Adds input port duty [3:0].
  - In ON, dig_n[idx] is low only when (ON counter mod 16) < duty; otherwise all 1s.
  - duty=0 gives a dark display with timing, slot_done and frame_done unchanged.
  - duty=15 gives 15/16 brightness.
  - duty is sampled every cycle.
- Undefined: port absent; digit driven for the full ON interval.

Decomposition:
- Package display_pkg:
  - state enum typedef (IDLE, GUARD, ON).
  - localparam CODE_W=5.
  - function digit_sel_n(idx, ndig) returning a one-hot active-low select.
- One natural sub-module, display_scan_timer: slot/guard down-counter with terminal-count outputs.
- Buffering and FSM stay in display_scan_ctrl.

Test Plan:
1. Reset while en=1, then release (NDIG=4, PRESC=16, GUARD=2) -> dig_n=4'b1111 and code_out=0 during reset; after release the first dig_n=4'b1110 appears 1+2 cycles after leaving IDLE and lasts 16 cycles.
2. upd with codes {5'd3,5'd2,5'd1,5'd0} while idle, then en=1 -> upd_ack one cycle later; code_out sequence 0,1,2,3; frame_done every 72 cycles.
3. Mid-frame upd of all 5'd31 during digit 1 -> digits 1..3 keep old codes this frame; next frame shows 31 on all digits.
4. upd coincident with the frame_done cycle -> next frame shows the previous staging; the following frame shows the new value.
5. en dropped during ON of digit 2 -> next cycle dig_n=1111 with no slot_done; re-enable restarts at digit 0 via GUARD.
6. With DISPLAY_SCAN_DIM_EN defined: duty=4 -> dig_n low on exactly 4 of every 16 ON cycles; duty=0 -> dig_n never low, frame_done still every 72 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
// Optional dimming is enabled with DISPLAY_SCAN_DIM_EN.
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_ON
  } state_t;

  localparam int CODE_W  = 5;
  localparam int MAX_DIG = 8;

  function automatic logic [MAX_DIG-1:0] digit_sel_n(
    input logic [2:0] idx,
    input int         ndig
  );
    logic [MAX_DIG-1:0] r;
    r = '1;
    if (int'(idx) < ndig) r[idx] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot/guard down-counter; tc flags the final cycle of an interval.
// Optional dimming (DISPLAY_SCAN_DIM_EN) lives in display_scan_ctrl.
module display_scan_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt_nxt,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_comb begin
    cnt_nxt = cnt - 1'b1;
    unique case (1'b1)
      clr:     cnt_nxt = '0;
      load:    cnt_nxt = load_val;
      default: ;
    endcase
  end

  assign tc = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scanner with double-buffered codes and blanking guard.
// Define DISPLAY_SCAN_DIM_EN to add the duty[3:0] brightness input.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int W     = CODE_W,
  parameter int PRESC = 1000,
  parameter int GUARD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            upd,
  input  logic [NDIG*W-1:0] codes,
`ifdef DISPLAY_SCAN_DIM_EN
  input  logic [3:0]      duty,
`endif
  output logic            upd_ack,
  output logic [W-1:0]    code_out,
  output logic [NDIG-1:0] dig_n,
  output logic            slot_done,
  output logic            frame_done
);

  localparam int CW = $clog2(PRESC);
  localparam int IW = (NDIG > 2) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] ON_LD = CW'(PRESC - 1);
  localparam logic [CW-1:0] GD_LD =
    CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [CW-1:0] SLOT_LD =
    (GUARD > 0) ? GD_LD : ON_LD;
  localparam state_t SLOT_ST =
    (GUARD > 0) ? S_GUARD : S_ON;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t        state, state_d;
  logic [IW-1:0] idx, idx_d;

  logic          t_clr, t_load, tc;
  logic [CW-1:0] t_val, cnt_nxt;

  logic [NDIG*W-1:0] staging, active, active_d;
  logic              pending, frame_end, xfer;

  logic [W-1:0]    code_d;
  logic [NDIG-1:0] dig_d;
  logic            slot_d, frame_d, lit;

  display_scan_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (t_clr),
    .load     (t_load),
    .load_val (t_val),
    .cnt_nxt  (cnt_nxt),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    t_clr   = 1'b0;
    t_load  = 1'b0;
    t_val   = SLOT_LD;
    if (!en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      t_clr   = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_d = SLOT_ST;
          idx_d   = '0;
          t_load  = 1'b1;
        end
        S_GUARD: if (tc) begin
          state_d = S_ON;
          t_load  = 1'b1;
          t_val   = ON_LD;
        end
        S_ON: if (tc) begin
          state_d = SLOT_ST;
          t_load  = 1'b1;
          idx_d   = (idx == LAST) ? '0 : idx + 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          t_clr   = 1'b1;
        end
      endcase
    end
  end

  // Active only changes between frames or while idle, so no frame tears.
  assign frame_end = en && (state == S_ON) && tc && (idx == LAST);
  assign xfer      = pending && ((state == S_IDLE) || frame_end);
  assign active_d  = xfer ? staging : active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
      active  <= '0;
      pending <= 1'b0;
      upd_ack <= 1'b0;
    end else begin
      if (upd) staging <= codes;
      active  <= active_d;
      pending <= upd | (pending & ~xfer);
      upd_ack <= upd;
    end
  end

`ifdef DISPLAY_SCAN_DIM_EN
  logic [3:0] phase_d;
  assign phase_d = 4'(ON_LD - cnt_nxt);
  assign lit     = (phase_d < duty);
`else
  assign lit = 1'b1;
`endif

  // Outputs are derived from next-state values so they line up with state.
  always_comb begin
    code_d  = '0;
    dig_d   = '1;
    slot_d  = 1'b0;
    frame_d = 1'b0;
    unique case (state_d)
      S_GUARD: code_d = active_d[W*int'(idx_d) +: W];
      S_ON: begin
        code_d = active_d[W*int'(idx_d) +: W];
        if (lit)
          dig_d = NDIG'(digit_sel_n(3'(idx_d), NDIG));
        slot_d  = (cnt_nxt == '0);
        frame_d = (cnt_nxt == '0) && (idx_d == LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out   <= '0;
      dig_n      <= '1;
      slot_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      code_out   <= code_d;
      dig_n      <= dig_d;
      slot_done  <= slot_d;
      frame_done <= frame_d;
    end
  end

endmodule
